sequenciador_rega: RTL and testbench

//  Irrigation cycle controller.
//  - Sequences tank fill (Ve), fertilizer mix (Mist), line cleaning (Limp) and irrigation
//    (A sprinkler / G drip) from a per-second tick.
//  - Arbitrates irrigation vs fertilization requests so only one runs at a time.
//  - Guarantees irrigation valves are closed during cleaning.
//  - Sits between the sensor/decision logic and the valve drivers / display selector.

---
 rtl/rega_pkg.sv | 24 ++
 rtl/rega_timer.sv | 44 ++++
 rtl/sequenciador_rega.sv | 224 ++++++++++++++++++++++
 tb/tb_sequenciador_rega.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation cycle controller.
// Contents: state codes (IDLE..ALARME), tank level constants and default phase durations.
package rega_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENCHER  = 3'd1,
        REGA    = 3'd2,
        MISTURA = 3'd3,
        LIMPEZA = 3'd4,
        ALARME  = 3'd5
    } estado_e;

    localparam logic [1:0] NV_VAZIO = 2'b00;
    localparam logic [1:0] NV_CHEIO = 2'b11;

    localparam int unsigned TW_DEF      = 8;
    localparam int unsigned ASP_T_DEF   = 30;
    localparam int unsigned GOT_T_DEF   = 90;
    localparam int unsigned MIX_T_DEF   = 20;
    localparam int unsigned LIMP_T_DEF  = 10;
    localparam int unsigned FILL_TO_DEF = 120;

endpackage

// File: rtl/rega_timer.sv
// Loadable down-counter with tick enable, used for phase durations and the fill timeout.
// Ports:
//   Clk   in   clock
//   Rst   in   synchronous active-high reset (count cleared to 0)
//   load  in   load val this cycle; has priority over tick
//   val   in   TW-bit load value
//   tick  in   decrement enable; counter saturates at 0
//   cnt   out  current count
//   zero  out  count == 0
module rega_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          load,
    input  logic [TW-1:0] val,
    input  logic          tick,
    output logic [TW-1:0] cnt,
    output logic          zero
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sequenciador_rega.sv
// Irrigation cycle controller: sequences tank fill, fertilizer mix, line cleaning and
// irrigation (sprinkler or drip) from a 1 Hz tick, one phase at a time.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   tick              1-cycle 1 Hz enable
//   rega_req          irrigation demand (level)
//   tipo_asp          1 = sprinkler, 0 = drip; sampled when irrigation starts
//   adub_req          fertilization request pulse (latched)
//   nivel             tank level 00 empty .. 11 full
//   A, G, Ve, Mist, Limp  registered valve / mixer outputs, at most one active
//   ocupado, estado   busy flag and current state code
//   tempo_rest        ticks left in a timed phase, 0 otherwise
//   alarme            fill timeout latched
// Optional feature macro: SEQ_ALARME_EN enables the fill timeout and the ALARME state;
// without it ENCHER waits indefinitely and alarme is tied 0.
module sequenciador_rega
    import rega_pkg::*;
#(
    parameter int unsigned TW      = TW_DEF,
    parameter int unsigned ASP_T   = ASP_T_DEF,
    parameter int unsigned GOT_T   = GOT_T_DEF,
    parameter int unsigned MIX_T   = MIX_T_DEF,
    parameter int unsigned LIMP_T  = LIMP_T_DEF,
    parameter int unsigned FILL_TO = FILL_TO_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          tick,
    input  logic          rega_req,
    input  logic          tipo_asp,
    input  logic          adub_req,
    input  logic [1:0]    nivel,
    output logic          A,
    output logic          G,
    output logic          Ve,
    output logic          Mist,
    output logic          Limp,
    output logic          ocupado,
    output logic [2:0]    estado,
    output logic [TW-1:0] tempo_rest,
    output logic          alarme
);

    estado_e state_q, state_d;
    logic    pend_q, pend_d;
    logic    tipo_q, tipo_d;
    // Set while ENCHER was entered from REGA, so the return keeps the remaining time.
    logic    resume_q, resume_d;
    logic    a_q, a_d, g_q, g_d, ve_q, ve_d, mist_q, mist_d, limp_q, limp_d;

    logic          pend_eff;
    logic          entering;
    logic          fresh_rega;
    logic          timed_q;
    logic          ph_load, ph_tick, ph_zero;
    logic [TW-1:0] ph_val, ph_cnt;
    logic          fill_zero;

    // A request pulse in this cycle counts as already pending.
    assign pend_eff = pend_q | adub_req;
    assign timed_q  = (state_q == REGA) || (state_q == MISTURA) || (state_q == LIMPEZA);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pend_eff) begin
                    state_d = (nivel != NV_CHEIO) ? ENCHER : MISTURA;
                end else if (rega_req) begin
                    state_d = (nivel == NV_VAZIO) ? ENCHER : REGA;
                end
            end
            ENCHER: begin
                if ((nivel == NV_CHEIO) || (!pend_eff && (nivel != NV_VAZIO))) begin
                    if (pend_eff) begin
                        state_d = MISTURA;
                    end else if (rega_req) begin
                        state_d = REGA;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fill_zero) begin
                    state_d = ALARME;
                end
            end
            REGA: begin
                if (ph_zero || !rega_req) begin
                    state_d = LIMPEZA;
                end else if (nivel == NV_VAZIO) begin
                    state_d = ENCHER;
                end
            end
            MISTURA: begin
                if (ph_zero) begin
                    state_d = LIMPEZA;
                end
            end
            LIMPEZA: begin
                if (ph_zero) begin
                    state_d = IDLE;
                end
            end
            ALARME:  state_d = ALARME;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        entering   = (state_d != state_q);
        fresh_rega = entering && (state_d == REGA) && !((state_q == ENCHER) && resume_q);

        resume_d = resume_q;
        if ((state_q == REGA) && (state_d == ENCHER)) begin
            resume_d = 1'b1;
        end else if ((state_q == ENCHER) && entering) begin
            resume_d = 1'b0;
        end

        tipo_d = fresh_rega ? tipo_asp : tipo_q;
        pend_d = (entering && (state_d == MISTURA)) ? 1'b0 : pend_eff;

        ph_load = entering && ((state_d == MISTURA) || (state_d == LIMPEZA) || fresh_rega);
        ph_tick = tick && timed_q;
        unique case (state_d)
            REGA:    ph_val = tipo_asp ? TW'(ASP_T) : TW'(GOT_T);
            MISTURA: ph_val = TW'(MIX_T);
            LIMPEZA: ph_val = TW'(LIMP_T);
            default: ph_val = '0;
        endcase

        a_d    = (state_d == REGA) && tipo_d;
        g_d    = (state_d == REGA) && !tipo_d;
        ve_d   = (state_d == ENCHER);
        mist_d = (state_d == MISTURA);
        limp_d = (state_d == LIMPEZA);
    end

    rega_timer #(
        .TW (TW)
    ) u_fase (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (ph_load),
        .val  (ph_val),
        .tick (ph_tick),
        .cnt  (ph_cnt),
        .zero (ph_zero)
    );

`ifdef SEQ_ALARME_EN
    logic          fill_load, fill_tick;
    logic [TW-1:0] fill_cnt;
    logic          alarme_q, alarme_d;

    // Reloaded on every ENCHER entry; counts only while filling.
    assign fill_load = entering && (state_d == ENCHER);
    assign fill_tick = tick && (state_q == ENCHER);
    assign alarme_d  = (state_d == ALARME);

    rega_timer #(
        .TW (TW)
    ) u_enchimento (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (fill_load),
        .val  (TW'(FILL_TO)),
        .tick (fill_tick),
        .cnt  (fill_cnt),
        .zero (fill_zero)
    );

    logic unused_fill_cnt;
    assign unused_fill_cnt = ^fill_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            alarme_q <= 1'b0;
        end else begin
            alarme_q <= alarme_d;
        end
    end

    assign alarme = alarme_q;
`else
    logic unused_fill_to;
    assign unused_fill_to = ^FILL_TO;
    assign fill_zero      = 1'b0;
    assign alarme         = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            tipo_q   <= 1'b0;
            resume_q <= 1'b0;
            a_q      <= 1'b0;
            g_q      <= 1'b0;
            ve_q     <= 1'b0;
            mist_q   <= 1'b0;
            limp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            tipo_q   <= tipo_d;
            resume_q <= resume_d;
            a_q      <= a_d;
            g_q      <= g_d;
            ve_q     <= ve_d;
            mist_q   <= mist_d;
            limp_q   <= limp_d;
        end
    end

    assign A          = a_q;
    assign G          = g_q;
    assign Ve         = ve_q;
    assign Mist       = mist_q;
    assign Limp       = limp_q;
    assign ocupado    = (state_q != IDLE);
    assign estado     = state_q;
    assign tempo_rest = timed_q ? ph_cnt : '0;

endmodule

// File: tb/tb_sequenciador_rega.sv
// Directed bench for sequenciador_rega. Observed outputs are packed as
// {A,G,Ve,Mist,Limp,alarme,ocupado,estado} and compared with tempo_rest.
module tb_sequenciador_rega;

    logic       Clk = 1'b0;
    logic       Rst, tick, rega_req, tipo_asp, adub_req;
    logic [1:0] nivel;
    logic       A, G, Ve, Mist, Limp, ocupado, alarme;
    logic [2:0] estado;
    logic [7:0] tempo_rest;
    logic [9:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [9:0] EXP_IDLE = 10'b00000_0_0_000;
    localparam logic [9:0] EXP_VE   = 10'b00100_0_1_001;
    localparam logic [9:0] EXP_A    = 10'b10000_0_1_010;
    localparam logic [9:0] EXP_G    = 10'b01000_0_1_010;
    localparam logic [9:0] EXP_MIST = 10'b00010_0_1_011;
    localparam logic [9:0] EXP_LIMP = 10'b00001_0_1_100;
    localparam logic [9:0] EXP_ALM  = 10'b00000_1_1_101;

    sequenciador_rega dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .tick       (tick),
        .rega_req   (rega_req),
        .tipo_asp   (tipo_asp),
        .adub_req   (adub_req),
        .nivel      (nivel),
        .A          (A),
        .G          (G),
        .Ve         (Ve),
        .Mist       (Mist),
        .Limp       (Limp),
        .ocupado    (ocupado),
        .estado     (estado),
        .tempo_rest (tempo_rest),
        .alarme     (alarme)
    );

    always #5 Clk = ~Clk;

    assign obs = {A, G, Ve, Mist, Limp, alarme, ocupado, estado};

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Each tick is one cycle high followed by one cycle low.
    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; tick = 1'b1; rega_req = 1'b1; tipo_asp = 1'b1; adub_req = 1'b1;
        nivel = 2'b11;
        repeat (3) step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_IDLE, 8'd0}) begin
            n_err++; $display("FAIL reset: got %b/%0d want %b/0", obs, tempo_rest, EXP_IDLE);
        end
        Rst = 1'b0; tick = 1'b0; rega_req = 1'b0; adub_req = 1'b0; nivel = 2'b10;
        step();
        n_cmp++;
        if (obs !== EXP_IDLE) begin
            n_err++; $display("FAIL reset_no_pend: got %b want %b", obs, EXP_IDLE);
        end
    endtask

    task automatic test_aspersao();
        rega_req = 1'b1; tipo_asp = 1'b1; nivel = 2'b10;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_A, 8'd30}) begin
            n_err++; $display("FAIL asp_entry: got %b/%0d want %b/30", obs, tempo_rest, EXP_A);
        end
        tipo_asp = 1'b0;
        give_ticks(29);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_A, 8'd1}) begin
            n_err++; $display("FAIL asp_t29: got %b/%0d want %b/1", obs, tempo_rest, EXP_A);
        end
        give_ticks(1);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_LIMP, 8'd10}) begin
            n_err++; $display("FAIL asp_limp: got %b/%0d want %b/10", obs, tempo_rest, EXP_LIMP);
        end
        give_ticks(5);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_LIMP, 8'd5}) begin
            n_err++; $display("FAIL limp_hold: got %b/%0d want %b/5", obs, tempo_rest, EXP_LIMP);
        end
        give_ticks(5);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_IDLE, 8'd0}) begin
            n_err++; $display("FAIL limp_end: got %b/%0d want %b/0", obs, tempo_rest, EXP_IDLE);
        end
        // Request still high: served from IDLE, with the newly sampled tipo.
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_G, 8'd90}) begin
            n_err++; $display("FAIL reentry_g: got %b/%0d want %b/90", obs, tempo_rest, EXP_G);
        end
        rega_req = 1'b0;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_LIMP, 8'd10}) begin
            n_err++; $display("FAIL req_drop: got %b/%0d want %b/10", obs, tempo_rest, EXP_LIMP);
        end
        give_ticks(10);
    endtask

    task automatic test_gotejamento_enchimento();
        rega_req = 1'b1; tipo_asp = 1'b0; nivel = 2'b10;
        step();
        give_ticks(40);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_G, 8'd50}) begin
            n_err++; $display("FAIL got_t40: got %b/%0d want %b/50", obs, tempo_rest, EXP_G);
        end
        nivel = 2'b00;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_VE, 8'd0}) begin
            n_err++; $display("FAIL got_empty: got %b/%0d want %b/0", obs, tempo_rest, EXP_VE);
        end
        give_ticks(3);
        nivel = 2'b01;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_G, 8'd50}) begin
            n_err++; $display("FAIL got_resume: got %b/%0d want %b/50", obs, tempo_rest, EXP_G);
        end
        give_ticks(50);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_LIMP, 8'd10}) begin
            n_err++; $display("FAIL got_end: got %b/%0d want %b/10", obs, tempo_rest, EXP_LIMP);
        end
        rega_req = 1'b0;
        give_ticks(10);
        // Empty tank at request: fill first, then a fresh full-length sprinkler phase.
        rega_req = 1'b1; nivel = 2'b00;
        step();
        n_cmp++;
        if (obs !== EXP_VE) begin
            n_err++; $display("FAIL fill_first: got %b want %b", obs, EXP_VE);
        end
        tipo_asp = 1'b1; nivel = 2'b01;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_A, 8'd30}) begin
            n_err++; $display("FAIL fill_fresh: got %b/%0d want %b/30", obs, tempo_rest, EXP_A);
        end
        rega_req = 1'b0;
        step();
        give_ticks(10);
    endtask

    task automatic test_adubacao_pendente();
        rega_req = 1'b1; tipo_asp = 1'b1; nivel = 2'b10;
        step();
        adub_req = 1'b1;
        step();
        adub_req = 1'b0;
        n_cmp++;
        if (obs !== EXP_A) begin
            n_err++; $display("FAIL adub_in_rega: got %b want %b", obs, EXP_A);
        end
        rega_req = 1'b0;
        step();
        give_ticks(10);
        n_cmp++;
        if (obs !== EXP_IDLE) begin
            n_err++; $display("FAIL adub_wait: got %b want %b", obs, EXP_IDLE);
        end
        step();
        nivel = 2'b01;
        step();
        n_cmp++;
        if (obs !== EXP_VE) begin
            n_err++; $display("FAIL adub_fill: got %b want %b", obs, EXP_VE);
        end
        nivel = 2'b11;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_MIST, 8'd20}) begin
            n_err++; $display("FAIL adub_mix: got %b/%0d want %b/20", obs, tempo_rest, EXP_MIST);
        end
        give_ticks(20);
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_LIMP, 8'd10}) begin
            n_err++; $display("FAIL mix_end: got %b/%0d want %b/10", obs, tempo_rest, EXP_LIMP);
        end
        give_ticks(10);
        step();
        n_cmp++;
        if (obs !== EXP_IDLE) begin
            n_err++; $display("FAIL pend_clear: got %b want %b", obs, EXP_IDLE);
        end
    endtask

    task automatic test_pedido_simultaneo();
        nivel = 2'b11; rega_req = 1'b1; tipo_asp = 1'b1; adub_req = 1'b1;
        step();
        adub_req = 1'b0;
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_MIST, 8'd20}) begin
            n_err++; $display("FAIL simul_mix: got %b/%0d want %b/20", obs, tempo_rest, EXP_MIST);
        end
        give_ticks(30);
        n_cmp++;
        if (obs !== EXP_IDLE) begin
            n_err++; $display("FAIL simul_idle: got %b want %b", obs, EXP_IDLE);
        end
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_A, 8'd30}) begin
            n_err++; $display("FAIL simul_rega: got %b/%0d want %b/30", obs, tempo_rest, EXP_A);
        end
        rega_req = 1'b0;
        step();
        give_ticks(10);
    endtask

    task automatic test_alarme();
        rega_req = 1'b1; tipo_asp = 1'b0; nivel = 2'b00;
        step();
`ifdef SEQ_ALARME_EN
        give_ticks(119);
        n_cmp++;
        if (obs !== EXP_VE) begin
            n_err++; $display("FAIL alm_t119: got %b want %b", obs, EXP_VE);
        end
        give_ticks(1);
        n_cmp++;
        if (obs !== EXP_ALM) begin
            n_err++; $display("FAIL alm_set: got %b want %b", obs, EXP_ALM);
        end
        nivel = 2'b11;
        give_ticks(5);
        n_cmp++;
        if (obs !== EXP_ALM) begin
            n_err++; $display("FAIL alm_hold: got %b want %b", obs, EXP_ALM);
        end
        rega_req = 1'b0; Rst = 1'b1;
        step();
        Rst = 1'b0;
        n_cmp++;
        if (obs !== EXP_IDLE) begin
            n_err++; $display("FAIL alm_rst: got %b want %b", obs, EXP_IDLE);
        end
`else
        give_ticks(130);
        n_cmp++;
        if (obs !== EXP_VE) begin
            n_err++; $display("FAIL fill_wait: got %b want %b", obs, EXP_VE);
        end
        nivel = 2'b01;
        step();
        n_cmp++;
        if ({obs, tempo_rest} !== {EXP_G, 8'd90}) begin
            n_err++; $display("FAIL fill_rega: got %b/%0d want %b/90", obs, tempo_rest, EXP_G);
        end
        rega_req = 1'b0;
        step();
        give_ticks(10);
        n_cmp++;
        if (obs !== EXP_IDLE) begin
            n_err++; $display("FAIL fill_done: got %b want %b", obs, EXP_IDLE);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_aspersao();
        test_gotejamento_enchimento();
        test_adubacao_pendente();
        test_pedido_simultaneo();
        test_alarme();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
